serial_flag_gen: RTL



---
 rtl/serial_flag_gen_pkg.sv | 17 +
 rtl/chunk_sub_cell.sv | 26 ++
 rtl/serial_flag_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_flag_gen_pkg.sv
// Shared types and default sizing for the serial compare / condition-flag unit.
package serial_flag_gen_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic {IDLE, BUSY} state_t;

  // Bit order matches flag_wdata: {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/chunk_sub_cell.sv
// One CHUNK-wide slice of a - b, computed as a + ~b + cin.
module chunk_sub_cell #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_lo,
  input  logic [CHUNK-1:0] b_lo,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] b_inv;
  logic [CHUNK:0]   sum_ext;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    b_inv    = ~b_lo;
    sum_ext  = {1'b0, a_lo} + {1'b0, b_inv} + {{CHUNK{1'b0}}, cin};
    sum      = sum_ext[CHUNK-1:0];
    cout     = sum_ext[CHUNK];
    // Carry into the MSB falls out of the MSB sum bit and its two addend bits.
    c_msb_in = sum_ext[CHUNK-1] ^ a_lo[CHUNK-1] ^ b_inv[CHUNK-1];
  end

endmodule

// File: rtl/serial_flag_gen.sv
// Multi-cycle a - b compare producing registered N/Z/C/V flags, CHUNK bits per cycle.
module serial_flag_gen
  import serial_flag_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  input  logic             flag_we,
  input  logic [3:0]       flag_wdata,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             zacc;
  logic [CNT_W-1:0] cnt;
  flags_t           flags;

  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             c_msb_in;
  logic             last;

  chunk_sub_cell #(.CHUNK(CHUNK)) u_cell (
    .a_lo     (a_sr[CHUNK-1:0]),
    .b_lo     (b_sr[CHUNK-1:0]),
    .cin      (carry),
    .sum      (sum),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  assign last   = (state == BUSY) && (cnt == LAST_CNT);
  assign ready  = (state == IDLE);
  assign flag_n = flags.n;
  assign flag_z = flags.z;
  assign flag_c = flags.c;
  assign flag_v = flags.v;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      cnt   <= '0;
      flags <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;

      // A completing compare takes priority over a direct flag load.
      if (last) begin
        flags <= '{n: sum[CHUNK-1], z: zacc & (sum == '0), c: cout, v: c_msb_in ^ cout};
        done  <= 1'b1;
      end else if (flag_we) begin
        flags <= flags_t'(flag_wdata);
      end

      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b1;
            zacc  <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          a_sr  <= a_sr >> CHUNK;
          b_sr  <= b_sr >> CHUNK;
          carry <= cout;
          zacc  <= zacc & (sum == '0);
          cnt   <= cnt + 1'b1;
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
